// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file: FSM states, default widths and the hardwired-zero address.
package regfile_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

  localparam rf_addr_t RF_ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: writeback clears, issue sets (set wins on same address); reg 0 never pending.
module regfile_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WR-1:0]              clr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  clr_addr,
  input  logic [NUM_WR-1:0]              set_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  set_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]              busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_WR; i++)
      if (clr_en[i]) pend_d[clr_addr[i]] = 1'b0;
    // Sets are applied last so a newly issued producer overrides a retiring one.
    for (int j = 0; j < NUM_WR; j++)
      if (set_en[j]) pend_d[set_addr[j]] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_RD; r++) busy[r] = pend_q[rd_addr[r]];
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with zero-sweep init and pending scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle writeback->read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           ready,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              sb_set_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  sb_set_addr,
  output logic                           wr_conflict
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(RF_ZERO_ADDR);

  rf_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               ready_q, ready_d;
  logic               conf_q, conf_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];

  logic               run;
  logic [NUM_WR-1:0]  wr_act;
  logic [NUM_RD-1:0]  sb_busy;
  logic [NUM_RD-1:0]  byp_hit;

  // Writes to reg 0 and anything during the sweep are dropped here, once, for every consumer.
  always_comb begin
    run = (state_q == RF_RUN);
    for (int i = 0; i < NUM_WR; i++)
      wr_act[i] = run && wr_en[i] && (wr_addr[i] != ZERO_A);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    case (state_q)
      RF_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end
      end
      RF_RUN: ;
    endcase
  end

  // Port order is program order, so later ports overwrite earlier ones on a shared address.
  always_comb begin
    mem_d = mem_q;
    if (state_q == RF_INIT) mem_d[ptr_q] = '0;
    for (int i = 0; i < NUM_WR; i++)
      if (wr_act[i]) mem_d[wr_addr[i]] = wr_data[i];
  end

  always_comb begin
    conf_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_act[i] && wr_act[j] && (wr_addr[i] == wr_addr[j])) conf_d = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    byp_hit = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (run && (rd_addr[r] != ZERO_A)) begin
        rd_data[r] = mem_q[rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NUM_WR; i++)
          if (wr_act[i] && (wr_addr[i] == rd_addr[r])) begin
            rd_data[r] = wr_data[i];
            byp_hit[r] = 1'b1;
          end
`endif
      end
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) rd_busy[r] = run && sb_busy[r] && !byp_hit[r];
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (wr_act),
    .clr_addr (wr_addr),
    .set_en   (sb_set_en & {NUM_WR{run}}),
    .set_addr (sb_set_addr),
    .rd_addr  (rd_addr),
    .busy     (sb_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      conf_q  <= conf_d;
    end
  end

  // Storage has no reset; the sweep provides the zero contents.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign ready       = ready_q;
  assign wr_conflict = conf_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected values tagged by cycle, a monitor compares them.
module tb_regfile_mp;
  localparam int NW = 2;
  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int K_RD = 0, K_BUSY = 1, K_CONF = 2, K_RDY = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   ready;
  logic [NW-1:0]          wr_en;
  logic [NW-1:0][AW-1:0]  wr_addr;
  logic [NW-1:0][DW-1:0]  wr_data;
  logic [NR-1:0][AW-1:0]  rd_addr;
  logic [NR-1:0][DW-1:0]  rd_data;
  logic [NR-1:0]          rd_busy;
  logic [NW-1:0]          sb_set_en;
  logic [NW-1:0][AW-1:0]  sb_set_addr;
  logic                   wr_conflict;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  string kname[4] = '{"rd_data", "rd_busy", "wr_conflict", "ready"};

  task automatic push(input int dly, input int kind, input int port, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + dly; e.kind = kind; e.port = port; e.val = v;
    q.push_back(e);
  endtask

  function automatic logic [31:0] got_val(input int kind, input int port);
    case (kind)
      K_RD:    return rd_data[port];
      K_BUSY:  return {31'b0, rd_busy[port]};
      K_CONF:  return {31'b0, wr_conflict};
      default: return {31'b0, ready};
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        checks++;
        if (q[i].cyc < cyc || got_val(q[i].kind, q[i].port) !== q[i].val) begin
          errors++;
          $display("FAIL %s port%0d cyc%0d got=%h exp=%h", kname[q[i].kind], q[i].port,
                   q[i].cyc, got_val(q[i].kind, q[i].port), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_en = '0; sb_set_en = '0;
  endtask

  task automatic expect_sweep();
    for (int k = 0; k < 32; k++) push(k, K_RDY, 0, 32'd0);
    push(32, K_RDY, 0, 32'd1);
  endtask

  logic [31:0] ref_mem [32];
  logic        ref_pend [32];
  logic        ref_conf;

  initial begin
    idle();
    wr_addr = '0; wr_data = '0; rd_addr = '0; sb_set_addr = '0;
    reset = 1'b1;
    // 1: three reset cycles, sweep length, all registers read zero.
    repeat (3) tick();
    reset = 1'b0;
    expect_sweep();
    repeat (32) tick();
    for (int g = 0; g < 8; g++) begin
      for (int p = 0; p < NR; p++) begin
        rd_addr[p] = AW'(g * 4 + p);
        push(0, K_RD, p, 32'd0);
        push(0, K_BUSY, p, 32'd0);
      end
      tick();
    end

    // 2: reset mid-sweep restarts it; writes during sweep are ignored.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 10; k++) push(k, K_RDY, 0, 32'd0);
    repeat (5) tick();
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
    wr_data[0] = 32'hDEAD0001; wr_data[1] = 32'hDEAD0002;
    push(1, K_CONF, 0, 32'd0);
    tick(); idle();
    repeat (4) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    expect_sweep();
    repeat (32) tick();
    rd_addr[3] = 5'd5; push(0, K_RD, 3, 32'd0);
    tick();

    // 3: same-address double write, then writes to r0.
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
    wr_data[0] = 32'hAAAA0000; wr_data[1] = 32'h5555FFFF;
    push(0, K_CONF, 0, 32'd0);
    push(1, K_CONF, 0, 32'd1);
    tick(); idle();
    rd_addr[0] = 5'd5; push(0, K_RD, 0, 32'h5555FFFF);
    tick();
    wr_en = 2'b11; wr_addr[0] = 5'd0; wr_addr[1] = 5'd0;
    wr_data[0] = 32'hFFFFFFFF; wr_data[1] = 32'hFFFFFFFF;
    rd_addr[1] = 5'd0; push(0, K_RD, 1, 32'd0);
    push(0, K_CONF, 0, 32'd0);
    push(1, K_CONF, 0, 32'd0);
    tick(); idle();
    rd_addr[1] = 5'd0; push(0, K_RD, 1, 32'd0);
    tick();

    // 4: write-then-read on r7, with and without forwarding.
    wr_en = 2'b10; wr_addr[1] = 5'd7; wr_data[1] = 32'h11111111;
    tick(); idle();
    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h12345678;
    rd_addr[2] = 5'd7; push(0, K_RD, 2, BYP ? 32'h12345678 : 32'h11111111);
    tick(); idle();
    push(0, K_RD, 2, 32'h12345678);
    tick();

    // 5: scoreboard set / clear / set-wins.
    sb_set_en = 2'b01; sb_set_addr[0] = 5'd9;
    rd_addr[1] = 5'd9; push(0, K_BUSY, 1, 32'd0);
    tick(); idle();
    push(0, K_BUSY, 1, 32'd1);
    tick();
    wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h00000099;
    rd_addr[0] = 5'd9;
    push(0, K_BUSY, 0, BYP ? 32'd0 : 32'd1);
    push(0, K_RD, 0, BYP ? 32'h99 : 32'h0);
    tick(); idle();
    push(0, K_BUSY, 0, 32'd0);
    push(0, K_RD, 0, 32'h99);
    tick();
    sb_set_en = 2'b10; sb_set_addr[1] = 5'd9;
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h000000AB;
    push(0, K_BUSY, 0, 32'd0);
    push(0, K_RD, 0, BYP ? 32'hAB : 32'h99);
    tick(); idle();
    push(0, K_BUSY, 0, 32'd1);
    push(0, K_RD, 0, 32'hAB);
    sb_set_en = 2'b01; sb_set_addr[0] = 5'd0;
    tick(); idle();
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd9;
    push(0, K_BUSY, 0, 32'd0);
    push(0, K_RD, 0, 32'd0);
    push(0, K_BUSY, 1, 32'd1);
    tick();

    // 6: randomized traffic against a reference model, from a fresh sweep.
    reset = 1'b1; tick(); reset = 1'b0;
    expect_sweep();
    repeat (32) tick();
    for (int a = 0; a < 32; a++) begin ref_mem[a] = '0; ref_pend[a] = 1'b0; end
    ref_conf = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic nc;
      for (int i = 0; i < NW; i++) begin
        wr_en[i]       = ($urandom_range(2) != 0);
        wr_addr[i]     = AW'($urandom_range(7));
        wr_data[i]     = $urandom;
        sb_set_en[i]   = ($urandom_range(3) == 0);
        sb_set_addr[i] = AW'($urandom_range(7));
      end
      for (int r = 0; r < NR; r++) begin
        logic [31:0] ed;
        logic        eb;
        rd_addr[r] = AW'($urandom_range(7));
        ed = '0; eb = 1'b0;
        if (rd_addr[r] != 0) begin
          ed = ref_mem[rd_addr[r]]; eb = ref_pend[rd_addr[r]];
          if (BYP)
            for (int i = 0; i < NW; i++)
              if (wr_en[i] && wr_addr[i] == rd_addr[r]) begin ed = wr_data[i]; eb = 1'b0; end
        end
        push(0, K_RD, r, ed);
        push(0, K_BUSY, r, {31'b0, eb});
      end
      push(0, K_CONF, 0, {31'b0, ref_conf});
      nc = 1'b0;
      for (int i = 0; i < NW; i++)
        for (int j = i + 1; j < NW; j++)
          if (wr_en[i] && wr_en[j] && wr_addr[i] == wr_addr[j] && wr_addr[i] != 0) nc = 1'b1;
      ref_conf = nc;
      for (int i = 0; i < NW; i++)
        if (wr_en[i] && wr_addr[i] != 0) begin
          ref_mem[wr_addr[i]] = wr_data[i];
          ref_pend[wr_addr[i]] = 1'b0;
        end
      for (int j = 0; j < NW; j++)
        if (sb_set_en[j]) ref_pend[sb_set_addr[j]] = 1'b1;
      ref_pend[0] = 1'b0;
      tick();
    end
    idle();
    repeat (3) tick();
    if (q.size() != 0) begin
      $display("FAIL unchecked expectations left=%0d exp=0", q.size());
      errors += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
